// File: rtl/code_req_pio.sv
// Avalon-MM PIO that sends a command code over a four-phase req/ack handshake.
// Software loads DATA, pulses CTRL[0], then polls STATUS for done or timeout.
module code_req_pio #(
  parameter int DATA_WIDTH = 8,
  parameter int TO_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic                  out_req,
  input  logic                  in_ack
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_DROP = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [DATA_WIDTH-1:0] data;
  logic [TO_WIDTH-1:0]   timeout_val;
  logic [TO_WIDTH-1:0]   cnt;
  logic                  done;
  logic                  timed_out;
  logic [31:0]           rd_mux;

  logic wr_en;
  logic start;
  logic to_hit;
  logic done_set;
  logic to_set;
  logic done_clr;
  logic to_clr;
  logic unused_bits;

  assign wr_en    = chipselect & ~write_n;
  assign start    = wr_en & (address == 2'd1) & writedata[0];
  assign done_clr = wr_en & (address == 2'd3) & writedata[1];
  assign to_clr   = wr_en & (address == 2'd3) & writedata[2];

  // Ack has priority: timeout only fires while in_ack is low.
  assign to_hit = (timeout_val != '0)
                & (cnt == timeout_val - TO_WIDTH'(1))
                & ~in_ack;

  assign done_set = (state == WAIT_DROP) & ~in_ack;
  assign to_set   = (state == REQ) & to_hit;

  assign unused_bits = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = REQ;
      end
      REQ: begin
        if (in_ack)      state_nxt = WAIT_DROP;
        else if (to_hit) state_nxt = IDLE;
      end
      WAIT_DROP: begin
        if (!in_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    out_req = (state == REQ);
  end

  assign out_port = data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data <= '0;
    end else if (wr_en && address == 2'd0 && state == IDLE) begin
      data <= writedata[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timeout_val <= '0;
    end else if (wr_en && address == 2'd2) begin
      timeout_val <= writedata[TO_WIDTH-1:0];
    end
  end

  // Saturating so a disabled timeout never wraps back through zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (state == REQ && state_nxt == REQ) begin
      if (!(&cnt)) cnt <= cnt + TO_WIDTH'(1);
    end else begin
      cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done      <= 1'b0;
      timed_out <= 1'b0;
    end else begin
      if (done_set)      done <= 1'b1;
      else if (done_clr) done <= 1'b0;
      if (to_set)        timed_out <= 1'b1;
      else if (to_clr)   timed_out <= 1'b0;
    end
  end

  always_comb begin
    rd_mux = '0;
    unique case (address)
      2'd0: rd_mux = 32'(data);
      2'd1: rd_mux = {28'd0, in_ack, timed_out, done,
                      (state != IDLE)};
      2'd2: rd_mux = 32'(timeout_val);
      2'd3: rd_mux = '0;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_mux;
  end

endmodule

// File: tb/tb_code_req_pio.sv
// Directed bench for code_req_pio: read expectations go through a scoreboard
// queue checked by a monitor one cycle after the read address is presented.
module tb_code_req_pio;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [7:0]  out_port;
  logic        out_req;
  logic        in_ack = 1'b0;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  exp_t q[$];
  logic rd_strobe = 1'b0;
  logic rd_vld = 1'b0;
  int   vecs = 0;
  int   errs = 0;

  code_req_pio #(.DATA_WIDTH(8), .TO_WIDTH(16)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .out_port  (out_port),
    .out_req   (out_req),
    .in_ack    (in_ack)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) rd_vld <= rd_strobe;

  always @(negedge clk) begin
    if (rd_vld) begin
      if (q.size() == 0) begin
        cmp("scoreboard_underflow", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        cmp(e.name, readdata, e.val);
      end
    end
  end

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  // Expects the register value as visible at the current negedge.
  task automatic rdchk(input logic [1:0] a, input logic [31:0] v,
                       input string nm);
    exp_t e;
    e.name = nm;
    e.val  = v;
    q.push_back(e);
    address   = a;
    rd_strobe = 1'b1;
    @(negedge clk);
    rd_strobe = 1'b0;
  endtask

  initial begin : stim
    int n;
    #2;
    cmp("reset_out_req", {31'd0, out_req}, 32'd0);
    cmp("reset_readdata", readdata, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    rdchk(0, 32'h0, "rst_data");
    rdchk(1, 32'h0, "rst_status");
    rdchk(2, 32'h0, "rst_timeout");
    rdchk(3, 32'h0, "rst_clear");

    // Basic handshake
    wr(0, 32'h5A);
    cmp("hs_out_port", {24'd0, out_port}, 32'h5A);
    rdchk(0, 32'h5A, "hs_data_rd");
    wr(1, 32'h1);
    cmp("hs_req_up", {31'd0, out_req}, 32'd1);
    repeat (3) @(negedge clk);
    in_ack = 1'b1;
    cmp("hs_req_before_ack_edge", {31'd0, out_req}, 32'd1);
    @(negedge clk);
    cmp("hs_req_fell", {31'd0, out_req}, 32'd0);
    rdchk(1, 32'h9, "hs_status_wait_drop");
    in_ack = 1'b0;
    @(negedge clk);
    rdchk(1, 32'h2, "hs_status_done");
    in_ack = 1'b1;
    rdchk(1, 32'hA, "hs_status_done_ack");
    in_ack = 1'b0;
    @(negedge clk);

    // Timeout after exactly 10 request cycles
    wr(3, 32'h6);
    wr(2, 32'd10);
    rdchk(2, 32'd10, "to_reg_rd");
    wr(1, 32'h1);
    n = 0;
    while (out_req && n < 50) begin
      n++;
      @(negedge clk);
    end
    cmp("to_req_cycles", n, 32'd10);
    rdchk(1, 32'h4, "to_status");

    // Busy protection
    wr(3, 32'h4);
    wr(1, 32'h1);
    wr(0, 32'h33);
    wr(1, 32'h1);
    cmp("busy_out_port", {24'd0, out_port}, 32'h5A);
    in_ack = 1'b1;
    repeat (2) @(negedge clk);
    in_ack = 1'b0;
    repeat (4) @(negedge clk);
    cmp("busy_no_second_req", {31'd0, out_req}, 32'd0);
    rdchk(1, 32'h2, "busy_status");
    rdchk(0, 32'h5A, "busy_data_rd");

    // Set/clear collision on done
    wr(3, 32'h2);
    rdchk(1, 32'h0, "col_cleared");
    wr(1, 32'h1);
    in_ack = 1'b1;
    @(negedge clk);
    in_ack     = 1'b0;
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = 2'd3;
    writedata  = 32'h2;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    rdchk(1, 32'h2, "col_set_wins");
    wr(3, 32'h6);
    rdchk(1, 32'h0, "col_clear_all");

    // Ack/timeout tie
    wr(2, 32'd4);
    wr(1, 32'h1);
    repeat (3) @(negedge clk);
    in_ack = 1'b1;
    @(negedge clk);
    cmp("tie_req_fell", {31'd0, out_req}, 32'd0);
    rdchk(1, 32'h9, "tie_wait_drop");
    in_ack = 1'b0;
    @(negedge clk);
    rdchk(1, 32'h2, "tie_no_timeout");
    wr(3, 32'h6);

    // Async reset mid-handshake
    wr(2, 32'd10);
    wr(1, 32'h1);
    cmp("ar_req_up", {31'd0, out_req}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    cmp("ar_req_drop", {31'd0, out_req}, 32'd0);
    cmp("ar_readdata", readdata, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    cmp("ar_out_port", {24'd0, out_port}, 32'd0);
    rdchk(1, 32'h0, "ar_status");
    rdchk(0, 32'h0, "ar_data");
    rdchk(2, 32'h0, "ar_timeout");

    repeat (2) @(negedge clk);
    cmp("scoreboard_empty", q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/code_req_pio.md
CODE_REQ_PIO -- requirements
Module: code_req_pio

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of out_port and of the DATA register.
REQ-002 Parameter TO_WIDTH, default 16: width of the TIMEOUT register and of the timeout counter.
REQ-003 clk  input  1  single clock; all state is on its rising edge.
REQ-004 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 address  input  2  Avalon-MM slave word address.
REQ-006 chipselect  input  1  slave select; qualifies writes.
REQ-007 write_n  input  1  active-low write strobe; a write occurs when chipselect=1 and write_n=0.
REQ-008 writedata  input  32  write data.
REQ-009 readdata  output  32  registered read data.
REQ-010 out_port  output  DATA_WIDTH  command code presented to the far end.
REQ-011 out_req  output  1  four-phase request to the far end.
REQ-012 in_ack  input  1  four-phase acknowledge from the far end, synchronous to clk.

Function
REQ-013 Register map: 0 DATA (RW); 1 CTRL/STATUS; 2 TIMEOUT (RW); 3 CLEAR (write-only, reads 0).
REQ-014 DATA write shall load writedata[DATA_WIDTH-1:0] in IDLE only; writes in any other state shall be ignored.
REQ-015 out_port shall equal DATA at all times.
REQ-016 A write to address 1 with writedata[0]=1 in IDLE shall enter REQ next cycle; in other states it shall be ignored.
REQ-017 STATUS read: bit0 busy (state != IDLE), bit1 done (sticky), bit2 timeout (sticky), bit3 in_ack, other bits 0.
REQ-018 Write to address 3: writedata[1]=1 clears done, writedata[2]=1 clears timeout; a clear in the same cycle as the set shall lose (the set wins).
REQ-019 readdata shall be updated every clock from the read mux for the current address, zero-extended, without a read strobe; one-cycle latency.
REQ-020 FSM states: IDLE, REQ, WAIT_DROP.
REQ-021 IDLE: out_req=0; timeout counter held at 0.
REQ-022 REQ: out_req=1; counter increments each cycle; the transition is checked before the increment.
REQ-023 REQ -> WAIT_DROP when in_ack=1; out_req falls the same edge.
REQ-024 REQ -> IDLE with timeout set when TIMEOUT != 0, counter == TIMEOUT-1 and in_ack=0.
REQ-025 When in_ack=1 and timeout both qualify in the same cycle, ack shall win.
REQ-026 TIMEOUT=0 disables the timeout; the counter shall then saturate at all ones and not wrap.
REQ-027 WAIT_DROP: out_req=0; -> IDLE with done set when in_ack=0; no timeout in this state.
REQ-028 A start request that is entered while in_ack is still 1 shall enter REQ and complete immediately to WAIT_DROP (no edge detection on in_ack).
REQ-029 A new start request in IDLE shall not clear done or timeout.
REQ-030 TIMEOUT writes shall be accepted in any state; in REQ the new value takes effect next cycle.

Reset
REQ-031 On reset_n=0, asynchronously: state=IDLE, out_req=0, DATA=0, TIMEOUT=0, counter=0, done=0, timeout=0, readdata=0.
REQ-032 Reset mid-handshake shall drop out_req immediately and set neither done nor timeout.

Verification
REQ-033 Basic handshake: write DATA=0x5A, write CTRL=1, raise in_ack 3 cycles after out_req, drop it 2 cycles later -> out_port=0x5A, out_req falls the edge after ack, STATUS reads 0x2 after ack drops (0xA while ack still high).
REQ-034 Timeout: TIMEOUT=10, start, in_ack held 0 -> out_req high exactly 10 cycles, STATUS=0x4, busy=0.
REQ-035 Busy protection: during REQ write DATA=0x33 and CTRL=1 -> out_port unchanged, no second handshake after completion.
REQ-036 Set/clear collision: clear done on the same edge WAIT_DROP exits -> done reads 1; a following CLEAR write of 0x6 -> STATUS=0x0.
REQ-037 Ack/timeout tie: TIMEOUT=4, in_ack rises on the 4th REQ cycle -> WAIT_DROP entered, timeout bit stays 0.
REQ-038 Async reset during REQ -> out_req=0 without a clock edge; after release, STATUS=0, DATA=0, readdata=0.
